riscv_mem: RTL and testbench
============================

// Module: riscv_mem
// PURPOSE
// - Memory-access pipeline stage between execute and riscv_wb. It takes one EX result per
//   handshake, issues the load/store command on the data bus, then passes the load function,
//   address/result and destination register to writeback.
// - Loads issue the bus command here. The load response (data_bif_ack/rdata) is consumed by WB.
// - Stores are posted: they complete at data_bif_gnt. The bus gives no ack for writes.
// PARAMETERS
// - ALIGN_CHECK  1  1: misaligned LH/LHU/LW/SH/SW are suppressed and flagged. 0: issued unchecked.
// - ADDR_W       32 width of data_bif_addr. Takes the low ADDR_W bits of the address.
// PORTS
// clk              in   1             clock
// rst              in   1             synchronous reset, active-high
// ex_mem_rdy       in   1             EX holds a valid op
// ex_mem_ack       out  1             stage accepts the op this cycle (combinational)
// ex_mem_ld_funct  in   LD_FUNCT_W    load function (LD_NOP if not a load)
// ex_mem_st_funct  in   ST_FUNCT_W    store function (ST_NOP if not a store)
// ex_mem_data      in   32            ALU result; this is the effective address for loads/stores
// ex_mem_wdata     in   32            store data (rs2)
// ex_mem_rsd       in   5             destination register
// data_bif_req     out  1             bus command valid
// data_bif_gnt     in   1             bus accepts the command
// data_bif_rnw     out  1             1 = read, 0 = write
// data_bif_addr    out  ADDR_W        word-aligned address {addr[ADDR_W-1:2],2'b00}
// data_bif_be      out  4             byte enables
// data_bif_wdata   out  32            lane-replicated store data
// mem_wb_rdy       out  1             WB payload valid
// mem_wb_ack       in   1             WB accepts the payload
// mem_wb_funct     out  LD_FUNCT_W    load function to WB
// mem_wb_data      out  32            address for loads, ALU result otherwise
// mem_wb_rsd       out  5             destination register (0 for stores)
// mem_misalign     out  1             one-cycle pulse: a misaligned access was suppressed
// BEHAVIOUR
// - State machine. States: EMPTY, CMD, WB_WAIT. Reset goes to EMPTY.
// - All registered outputs reset to 0 (req, rnw, addr, be, wdata, rdy, funct=LD_NOP, data, rsd, misalign).
// - ex_mem_ack = (EMPTY) | (WB_WAIT & mem_wb_ack).
// - Accept happens when ex_mem_rdy & ex_mem_ack. On accept, the stage captures the payload.
// - Next state after accept:
//   - a load or store with a legal alignment goes to CMD, with req=1 the following cycle;
//   - an ALU op (both functs NOP) goes to WB_WAIT directly, so latency is 1 cycle;
//   - a misaligned access (ALIGN_CHECK=1) goes to WB_WAIT as LD_NOP with rsd=0, and mem_misalign
//     pulses for 1 cycle.
// - Misalignment rules: LH/LHU/SH when addr[0]=1; LW/SW when addr[1:0]!=0. LB/LBU/SB are never
//   misaligned.
// - Loads and stores both non-NOP is illegal. Sim-only check: $display + $finish.
// - In CMD, req, rnw, addr, be and wdata are held stable until gnt.
//   - gnt moves the stage to WB_WAIT, and req=0 from the next cycle.
//   - Back-to-back commands therefore have at least one idle bus cycle.
// - Byte enables: SB/LB/LBU = 4'b0001<<addr[1:0]; SH/LH/LHU = 4'b0011<<addr[1:0]; SW/LW = 4'b1111.
// - Store data: SB replicates {4{wdata[7:0]}}; SH replicates {2{wdata[15:0]}}; SW passes wdata.
// - WB_WAIT: mem_wb_rdy=1 and the payload is held until mem_wb_ack.
//   - Stores present funct=LD_NOP, rsd=0 and data=address.
//   - On ack: if ex_mem_rdy, accept the next op in the same cycle (zero bubble); otherwise go to
//     EMPTY and set rdy=0.
// - Load ordering: WB acks a load only after data_bif_ack. The stage therefore never issues a
//   second command while a load is outstanding, because CMD is only reachable after the
//   WB_WAIT handshake.
// - Reset mid-operation: req drops in the cycle after rst is sampled. Any pending op is discarded.
//   The bus is reset alongside the core.
// STRUCTURE
// - Shared package riscv_functions.vh: add ST_FUNCT_W=2 and ST_NOP/ST_SB/ST_SH/ST_SW.
//   LD_* encodings are reused. The MEM state encodings also go in the package.
// - Sub-module riscv_mem_lane (combinational) generates be and wdata from funct + addr[1:0] +
//   wdata, and produces the misalign flag.
// TESTING
// - ALU op: data=0x1234, rsd=5, WB acks at once -> mem_wb_rdy 1 cycle after accept,
//   data=0x1234, rsd=5, funct=LD_NOP, data_bif_req never set.
// - LW at 0x100, gnt after 3 cycles -> req held 3 cycles with addr=0x100, be=4'hF, rnw=1.
//   WB_WAIT follows with funct=LD_LW, data=0x100. Hold until ack.
// - SB at 0x203, wdata=0xAB, gnt immediate -> be=4'b1000, wdata=0xABABABAB, rnw=0.
//   WB payload: rsd=0, funct=LD_NOP.
// - LH at 0x101 (ALIGN_CHECK=1) -> no req, mem_misalign pulses 1 cycle, WB gets LD_NOP, rsd=0.
// - Back-to-back ALU ops with mem_wb_ack tied 1 and ex_mem_rdy tied 1 -> one op per cycle,
//   ex_mem_ack stays 1.
// - rst asserted while in CMD with req=1 -> the next cycle has req=0, rdy=0, ex_mem_ack=1 (EMPTY).

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg
//   Shared encodings for the memory-access stage.
//   - LD_* load function codes. They travel from execute through MEM to writeback.
//   - ST_* store function codes. They are consumed entirely inside MEM.
//   - mem_state_e is the MEM stage control state.
//   - acc_size_e and its decode helpers are used by the lane generator.
package riscv_mem_pkg;

  localparam int LD_FUNCT_W = 3;
  localparam logic [LD_FUNCT_W-1:0] LD_NOP = 3'd0;
  localparam logic [LD_FUNCT_W-1:0] LD_LB  = 3'd1;
  localparam logic [LD_FUNCT_W-1:0] LD_LH  = 3'd2;
  localparam logic [LD_FUNCT_W-1:0] LD_LW  = 3'd3;
  localparam logic [LD_FUNCT_W-1:0] LD_LBU = 3'd4;
  localparam logic [LD_FUNCT_W-1:0] LD_LHU = 3'd5;

  localparam int ST_FUNCT_W = 2;
  localparam logic [ST_FUNCT_W-1:0] ST_NOP = 2'd0;
  localparam logic [ST_FUNCT_W-1:0] ST_SB  = 2'd1;
  localparam logic [ST_FUNCT_W-1:0] ST_SH  = 2'd2;
  localparam logic [ST_FUNCT_W-1:0] ST_SW  = 2'd3;

  typedef enum logic [1:0] {
    MEM_EMPTY   = 2'd0,
    MEM_CMD     = 2'd1,
    MEM_WB_WAIT = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } acc_size_e;

  function automatic acc_size_e ld_size(input logic [LD_FUNCT_W-1:0] f);
    case (f)
      LD_LB, LD_LBU: ld_size = SZ_BYTE;
      LD_LH, LD_LHU: ld_size = SZ_HALF;
      LD_LW:         ld_size = SZ_WORD;
      default:       ld_size = SZ_NONE;
    endcase
  endfunction

  function automatic acc_size_e st_size(input logic [ST_FUNCT_W-1:0] f);
    case (f)
      ST_SB:   st_size = SZ_BYTE;
      ST_SH:   st_size = SZ_HALF;
      ST_SW:   st_size = SZ_WORD;
      default: st_size = SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/riscv_mem_lane.sv
// riscv_mem_lane
//   Combinational byte-lane generator for the memory stage.
//   Ports:
//     ld_funct_i  in   load function (LD_NOP if none)
//     st_funct_i  in   store function (ST_NOP if none)
//     addr_lo_i   in   address bits [1:0]
//     wdata_i     in   raw store data (rs2)
//     be_o        out  byte enables for the access
//     wdata_o     out  store data replicated across the lanes
//     misalign_o  out  access size is not naturally aligned at addr_lo_i
module riscv_mem_lane
  import riscv_mem_pkg::*;
(
  input  logic [LD_FUNCT_W-1:0] ld_funct_i,
  input  logic [ST_FUNCT_W-1:0] st_funct_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [31:0]           wdata_i,
  output logic [3:0]            be_o,
  output logic [31:0]           wdata_o,
  output logic                  misalign_o
);

  acc_size_e acc_size;
  acc_size_e wr_size;

  assign wr_size = st_size(st_funct_i);

  // A store's size wins when picking the byte enables. Both functs set at
  // once is illegal and gets trapped in the stage itself.
  always_comb begin
    acc_size   = (st_funct_i != ST_NOP) ? wr_size : ld_size(ld_funct_i);
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (acc_size)
      SZ_BYTE: be_o = 4'b0001 << addr_lo_i;
      SZ_HALF: begin
        // addr 3 shifts the upper enable bit out, which leaves 4'b1000.
        // That case is only issued when alignment checking is off.
        be_o       = 4'b0011 << addr_lo_i;
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        be_o       = 4'b1111;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: ;
    endcase
  end

  // Each byte lane picks its source byte according to the store size.
  // This makes the data valid on any lane that the enables select.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_o[8*gi +: 8] =
        (wr_size == SZ_BYTE) ? wdata_i[7:0] :
        (wr_size == SZ_HALF) ? wdata_i[8*(gi%2) +: 8] :
                               wdata_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/riscv_mem.sv
// riscv_mem
//   Memory-access pipeline stage between execute and writeback.
//   The stage accepts one EX result per handshake. For loads and stores it
//   issues a command on the data bus. It then hands the load function, the
//   address or result, and the destination register on to writeback.
//   Stores are posted and complete at grant. Load responses go to WB.
//   Ports:
//     clk, rst              clock; synchronous active-high reset
//     ex_mem_*              EX -> MEM handshake (rdy/ack) and payload
//     data_bif_*            data bus command (req/gnt handshake)
//     mem_wb_*              MEM -> WB handshake (rdy/ack) and payload
//     mem_misalign          one-cycle pulse when a misaligned access is dropped
//   Parameters:
//     ALIGN_CHECK  1: suppress and flag misaligned half/word accesses
//     ADDR_W       bus address width (3..32), taken from the low address bits
module riscv_mem
  import riscv_mem_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int ADDR_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // execute side
  input  logic                  ex_mem_rdy,
  output logic                  ex_mem_ack,
  input  logic [LD_FUNCT_W-1:0] ex_mem_ld_funct,
  input  logic [ST_FUNCT_W-1:0] ex_mem_st_funct,
  input  logic [31:0]           ex_mem_data,
  input  logic [31:0]           ex_mem_wdata,
  input  logic [4:0]            ex_mem_rsd,
  // data bus
  output logic                  data_bif_req,
  input  logic                  data_bif_gnt,
  output logic                  data_bif_rnw,
  output logic [ADDR_W-1:0]     data_bif_addr,
  output logic [3:0]            data_bif_be,
  output logic [31:0]           data_bif_wdata,
  // writeback side
  output logic                  mem_wb_rdy,
  input  logic                  mem_wb_ack,
  output logic [LD_FUNCT_W-1:0] mem_wb_funct,
  output logic [31:0]           mem_wb_data,
  output logic [4:0]            mem_wb_rsd,
  output logic                  mem_misalign
);

  mem_state_e state_q, state_d;

  logic                  req_q,      req_d;
  logic                  rnw_q,      rnw_d;
  logic [ADDR_W-1:0]     addr_q,     addr_d;
  logic [3:0]            be_q,       be_d;
  logic [31:0]           wdata_q,    wdata_d;
  logic                  rdy_q,      rdy_d;
  logic [LD_FUNCT_W-1:0] funct_q,    funct_d;
  logic [31:0]           data_q,     data_d;
  logic [4:0]            rsd_q,      rsd_d;
  logic                  misalign_q, misalign_d;

  logic        is_ld;
  logic        is_st;
  logic        accept;
  logic        bad_align;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misalign;

  riscv_mem_lane u_lane (
    .ld_funct_i (ex_mem_ld_funct),
    .st_funct_i (ex_mem_st_funct),
    .addr_lo_i  (ex_mem_data[1:0]),
    .wdata_i    (ex_mem_wdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_misalign)
  );

  assign is_ld     = (ex_mem_ld_funct != LD_NOP);
  assign is_st     = (ex_mem_st_funct != ST_NOP);
  assign bad_align = ALIGN_CHECK && lane_misalign;

  // Taking a new op while WB acks the current one gives zero-bubble flow
  // through the stage.
  assign ex_mem_ack = (state_q == MEM_EMPTY) ||
                      ((state_q == MEM_WB_WAIT) && mem_wb_ack);
  assign accept     = ex_mem_rdy && ex_mem_ack;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdy_d      = rdy_q;
    funct_d    = funct_q;
    data_d     = data_q;
    rsd_d      = rsd_q;
    misalign_d = 1'b0;

    case (state_q)
      MEM_CMD: begin
        if (data_bif_gnt) begin
          req_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = MEM_WB_WAIT;
        end
      end
      MEM_WB_WAIT: begin
        if (mem_wb_ack && !ex_mem_rdy) begin
          rdy_d   = 1'b0;
          state_d = MEM_EMPTY;
        end
      end
      default: ;
    endcase

    // Capture overrides the hold and drain paths above. It can only fire
    // in EMPTY, or in WB_WAIT on the same cycle as the WB ack.
    if (accept) begin
      data_d = ex_mem_data;
      if ((is_ld || is_st) && !bad_align) begin
        state_d = MEM_CMD;
        req_d   = 1'b1;
        rnw_d   = is_ld;
        addr_d  = {ex_mem_data[ADDR_W-1:2], 2'b00};
        be_d    = lane_be;
        wdata_d = lane_wdata;
        rdy_d   = 1'b0;
        funct_d = is_ld ? ex_mem_ld_funct : LD_NOP;
        rsd_d   = is_ld ? ex_mem_rsd : 5'd0;
      end else begin
        // ALU result or a dropped misaligned access. Either way there is
        // nothing to do on the bus.
        state_d    = MEM_WB_WAIT;
        req_d      = 1'b0;
        rdy_d      = 1'b1;
        funct_d    = bad_align ? LD_NOP : ex_mem_ld_funct;
        rsd_d      = bad_align ? 5'd0 : ex_mem_rsd;
        misalign_d = bad_align;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_EMPTY;
      req_q      <= 1'b0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'd0;
      rdy_q      <= 1'b0;
      funct_q    <= LD_NOP;
      data_q     <= 32'd0;
      rsd_q      <= 5'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
      funct_q    <= funct_d;
      data_q     <= data_d;
      rsd_q      <= rsd_d;
      misalign_q <= misalign_d;
    end
  end

  // EX must never present a load and a store together. This check exists
  // only in simulation.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      assert (!(is_ld && is_st))
        else $fatal(1, "riscv_mem: load and store functions both set");
    end
  end

  assign data_bif_req   = req_q;
  assign data_bif_rnw   = rnw_q;
  assign data_bif_addr  = addr_q;
  assign data_bif_be    = be_q;
  assign data_bif_wdata = wdata_q;
  assign mem_wb_rdy     = rdy_q;
  assign mem_wb_funct   = funct_q;
  assign mem_wb_data    = data_q;
  assign mem_wb_rsd     = rsd_q;
  assign mem_misalign   = misalign_q;

endmodule

// File: tb/tb_riscv_mem.sv
module tb_riscv_mem;
  import riscv_mem_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ex_mem_rdy;
  logic                  ex_mem_ack;
  logic [LD_FUNCT_W-1:0] ex_mem_ld_funct;
  logic [ST_FUNCT_W-1:0] ex_mem_st_funct;
  logic [31:0]           ex_mem_data;
  logic [31:0]           ex_mem_wdata;
  logic [4:0]            ex_mem_rsd;
  logic                  data_bif_req;
  logic                  data_bif_gnt;
  logic                  data_bif_rnw;
  logic [31:0]           data_bif_addr;
  logic [3:0]            data_bif_be;
  logic [31:0]           data_bif_wdata;
  logic                  mem_wb_rdy;
  logic                  mem_wb_ack;
  logic [LD_FUNCT_W-1:0] mem_wb_funct;
  logic [31:0]           mem_wb_data;
  logic [4:0]            mem_wb_rsd;
  logic                  mem_misalign;

  int checks   = 0;
  int failures = 0;

  riscv_mem #(.ALIGN_CHECK(1'b1), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_mem_rdy      (ex_mem_rdy),
    .ex_mem_ack      (ex_mem_ack),
    .ex_mem_ld_funct (ex_mem_ld_funct),
    .ex_mem_st_funct (ex_mem_st_funct),
    .ex_mem_data     (ex_mem_data),
    .ex_mem_wdata    (ex_mem_wdata),
    .ex_mem_rsd      (ex_mem_rsd),
    .data_bif_req    (data_bif_req),
    .data_bif_gnt    (data_bif_gnt),
    .data_bif_rnw    (data_bif_rnw),
    .data_bif_addr   (data_bif_addr),
    .data_bif_be     (data_bif_be),
    .data_bif_wdata  (data_bif_wdata),
    .mem_wb_rdy      (mem_wb_rdy),
    .mem_wb_ack      (mem_wb_ack),
    .mem_wb_funct    (mem_wb_funct),
    .mem_wb_data     (mem_wb_data),
    .mem_wb_rsd      (mem_wb_rsd),
    .mem_misalign    (mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic [LD_FUNCT_W-1:0] ld,
                       input logic [ST_FUNCT_W-1:0] st, input logic [31:0] d,
                       input logic [31:0] wd, input logic [4:0] rsd);
    ex_mem_rdy      = rdy;
    ex_mem_ld_funct = ld;
    ex_mem_st_funct = st;
    ex_mem_data     = d;
    ex_mem_wdata    = wd;
    ex_mem_rsd      = rsd;
  endtask

  initial begin
    rst          = 1'b1;
    data_bif_gnt = 1'b0;
    mem_wb_ack   = 1'b0;
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    step();
    step();

    // Reset state
    chk("rst_req",   {31'd0, data_bif_req},   32'd0);
    chk("rst_rnw",   {31'd0, data_bif_rnw},   32'd0);
    chk("rst_addr",  data_bif_addr,           32'd0);
    chk("rst_be",    {28'd0, data_bif_be},    32'd0);
    chk("rst_wdata", data_bif_wdata,          32'd0);
    chk("rst_rdy",   {31'd0, mem_wb_rdy},     32'd0);
    chk("rst_funct", {29'd0, mem_wb_funct},   {29'd0, LD_NOP});
    chk("rst_data",  mem_wb_data,             32'd0);
    chk("rst_rsd",   {27'd0, mem_wb_rsd},     32'd0);
    chk("rst_mis",   {31'd0, mem_misalign},   32'd0);
    rst = 1'b0;
    step();
    chk("empty_ack", {31'd0, ex_mem_ack}, 32'd1);

    // ALU op: result reaches WB one cycle after accept; no bus traffic
    mem_wb_ack = 1'b1;
    drive(1'b1, LD_NOP, ST_NOP, 32'h1234, 32'd0, 5'd5);
    step();
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    chk("alu_rdy",   {31'd0, mem_wb_rdy},   32'd1);
    chk("alu_data",  mem_wb_data,           32'h1234);
    chk("alu_rsd",   {27'd0, mem_wb_rsd},   32'd5);
    chk("alu_funct", {29'd0, mem_wb_funct}, {29'd0, LD_NOP});
    chk("alu_req",   {31'd0, data_bif_req}, 32'd0);
    step();
    chk("alu_drain_rdy", {31'd0, mem_wb_rdy},   32'd0);
    chk("alu_drain_req", {31'd0, data_bif_req}, 32'd0);

    // LW at 0x100; the grant arrives in the third cycle of req
    mem_wb_ack = 1'b0;
    drive(1'b1, LD_LW, ST_NOP, 32'h100, 32'd0, 5'd7);
    step();
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("lw_req_c%0d", c),  {31'd0, data_bif_req}, 32'd1);
      chk($sformatf("lw_addr_c%0d", c), data_bif_addr,         32'h100);
      chk($sformatf("lw_be_c%0d", c),   {28'd0, data_bif_be},  32'hF);
      chk($sformatf("lw_rnw_c%0d", c),  {31'd0, data_bif_rnw}, 32'd1);
      chk($sformatf("lw_exack_c%0d", c), {31'd0, ex_mem_ack},  32'd0);
      chk($sformatf("lw_rdy_c%0d", c),  {31'd0, mem_wb_rdy},   32'd0);
      if (c == 3) data_bif_gnt = 1'b1;
      step();
    end
    data_bif_gnt = 1'b0;
    chk("lw_req_off", {31'd0, data_bif_req}, 32'd0);
    chk("lw_wb_rdy",  {31'd0, mem_wb_rdy},   32'd1);
    chk("lw_funct",   {29'd0, mem_wb_funct}, {29'd0, LD_LW});
    chk("lw_data",    mem_wb_data,           32'h100);
    chk("lw_rsd",     {27'd0, mem_wb_rsd},   32'd7);
    step();
    chk("lw_hold_rdy",  {31'd0, mem_wb_rdy},   32'd1);
    chk("lw_hold_data", mem_wb_data,           32'h100);
    chk("lw_wait_exack", {31'd0, ex_mem_ack},  32'd0);
    mem_wb_ack = 1'b1;
    #1;
    chk("lw_ack_exack", {31'd0, ex_mem_ack}, 32'd1);
    step();
    chk("lw_drain_rdy", {31'd0, mem_wb_rdy}, 32'd0);

    // SB at 0x203 with an immediate grant
    mem_wb_ack   = 1'b0;
    data_bif_gnt = 1'b1;
    drive(1'b1, LD_NOP, ST_SB, 32'h203, 32'h0000_00AB, 5'd9);
    step();
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    chk("sb_req",   {31'd0, data_bif_req}, 32'd1);
    chk("sb_be",    {28'd0, data_bif_be},  32'h8);
    chk("sb_wdata", data_bif_wdata,        32'hABAB_ABAB);
    chk("sb_rnw",   {31'd0, data_bif_rnw}, 32'd0);
    chk("sb_addr",  data_bif_addr,         32'h200);
    step();
    data_bif_gnt = 1'b0;
    chk("sb_req_off", {31'd0, data_bif_req}, 32'd0);
    chk("sb_rdy",     {31'd0, mem_wb_rdy},   32'd1);
    chk("sb_rsd",     {27'd0, mem_wb_rsd},   32'd0);
    chk("sb_funct",   {29'd0, mem_wb_funct}, {29'd0, LD_NOP});
    chk("sb_data",    mem_wb_data,           32'h203);
    mem_wb_ack = 1'b1;
    step();

    // SH at 0x002: upper half-word lanes, replicated data
    mem_wb_ack   = 1'b0;
    data_bif_gnt = 1'b1;
    drive(1'b1, LD_NOP, ST_SH, 32'h2, 32'h1234_CDEF, 5'd4);
    step();
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    chk("sh_be",    {28'd0, data_bif_be}, 32'hC);
    chk("sh_wdata", data_bif_wdata,       32'hCDEF_CDEF);
    step();
    data_bif_gnt = 1'b0;
    mem_wb_ack   = 1'b1;
    step();

    // LH at 0x101 is misaligned: dropped, flagged, passed on as a NOP
    mem_wb_ack = 1'b0;
    drive(1'b1, LD_LH, ST_NOP, 32'h101, 32'd0, 5'd3);
    step();
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    chk("lh_mis",   {31'd0, mem_misalign}, 32'd1);
    chk("lh_req",   {31'd0, data_bif_req}, 32'd0);
    chk("lh_rdy",   {31'd0, mem_wb_rdy},   32'd1);
    chk("lh_funct", {29'd0, mem_wb_funct}, {29'd0, LD_NOP});
    chk("lh_rsd",   {27'd0, mem_wb_rsd},   32'd0);
    step();
    chk("lh_mis_pulse", {31'd0, mem_misalign}, 32'd0);
    chk("lh_req2",      {31'd0, data_bif_req}, 32'd0);
    mem_wb_ack = 1'b1;
    step();

    // SW at 0x001 is misaligned as well
    mem_wb_ack = 1'b0;
    drive(1'b1, LD_NOP, ST_SW, 32'h1, 32'hDEAD_BEEF, 5'd2);
    step();
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    chk("sw_mis", {31'd0, mem_misalign}, 32'd1);
    chk("sw_req", {31'd0, data_bif_req}, 32'd0);
    mem_wb_ack = 1'b1;
    step();

    // Back-to-back ALU ops, one per cycle
    mem_wb_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, LD_NOP, ST_NOP, 32'h50 + i, 32'd0, 5'(10 + i));
      step();
      chk($sformatf("b2b_data_%0d", i),  mem_wb_data,         32'h50 + i);
      chk($sformatf("b2b_rsd_%0d", i),   {27'd0, mem_wb_rsd}, 32'(10 + i));
      chk($sformatf("b2b_exack_%0d", i), {31'd0, ex_mem_ack}, 32'd1);
    end
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    step();
    chk("b2b_drain_rdy", {31'd0, mem_wb_rdy}, 32'd0);

    // Reset while a command is pending on the bus
    mem_wb_ack   = 1'b0;
    data_bif_gnt = 1'b0;
    drive(1'b1, LD_LW, ST_NOP, 32'h40, 32'd0, 5'd8);
    step();
    drive(1'b0, LD_NOP, ST_NOP, 32'd0, 32'd0, 5'd0);
    chk("rstcmd_req_before", {31'd0, data_bif_req}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rstcmd_req",   {31'd0, data_bif_req}, 32'd0);
    chk("rstcmd_rdy",   {31'd0, mem_wb_rdy},   32'd0);
    chk("rstcmd_exack", {31'd0, ex_mem_ack},   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
